// File: rtl/reg_file_wb.sv
`timescale 1ns/1ps
// MIPS 32x32 register file: two combinational read ports (ID) and one write port (WB); $0 reads zero, $sp resets to SP_RESET.
// Latency: reads are zero-cycle combinational; a write commits on the rising clk edge.
// Backpressure: none, a write is accepted every cycle. Macro REGFILE_BYPASS_EN turns on write-first read bypass.
module reg_file_wb #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_3FFC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Write_reg,
    input  logic [DATA_W-1:0] Write_data,
    input  logic [ADDR_W-1:0] Read_reg_1,
    input  logic [ADDR_W-1:0] Read_reg_2,
    output logic [DATA_W-1:0] Read_data_1,
    output logic [DATA_W-1:0] Read_data_2,
    output logic [15:0]       Write_count
);

    localparam int NREG   = 2 ** ADDR_W;
    localparam int SP_IDX = 29;

    // Flop-based storage so the asynchronous clear is legal; entry 0 is never written.
    logic [DATA_W-1:0] regs [NREG];
    logic              wr_en;

    assign wr_en = RegWrite && (Write_reg != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
            Write_count <= '0;
        end else if (wr_en) begin
            regs[Write_reg] <= Write_data;
            Write_count     <= Write_count + 16'd1;
        end
    end

    always_comb begin
        Read_data_1 = regs[Read_reg_1];
`ifdef REGFILE_BYPASS_EN
        // Bypass is suppressed in reset so reads show the reset image.
        if (reset_n && wr_en && (Read_reg_1 == Write_reg)) begin
            Read_data_1 = Write_data;
        end
`endif
        if (Read_reg_1 == '0) begin
            Read_data_1 = '0;
        end
    end

    always_comb begin
        Read_data_2 = regs[Read_reg_2];
`ifdef REGFILE_BYPASS_EN
        if (reset_n && wr_en && (Read_reg_2 == Write_reg)) begin
            Read_data_2 = Write_data;
        end
`endif
        if (Read_reg_2 == '0) begin
            Read_data_2 = '0;
        end
    end

endmodule
